regfile_multiport: RTL and testbench
====================================

Name: regfile_multiport

Overview:
Parametrised successor to the core's 32x32 register file: configurable width, depth and read-port count. Adds per-byte write strobes, a hardwired zero register and a hardware clear sequencer that zeroes the array one entry per cycle. Sits in the decode/writeback stage of the datapath; reads are combinational, writes commit on the rising clock edge.

Parameters:
DATA_W, 32, register width in bits; must be a multiple of 8
NUM_REGS, 32, number of entries; 2..256, need not be a power of two
NUM_RD, 2, number of independent combinational read ports; 1..4
ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes; 0 = entry 0 is an ordinary register
(localparam) ADDR_W = $clog2(NUM_REGS); STRB_W = DATA_W/8

Ports:
clk  in  1  system clock, rising-edge active
rst  in  1  asynchronous, active-high reset
we  in  1  write enable
waddr  in  ADDR_W  write address
wdata  in  DATA_W  write data
wstrb  in  STRB_W  byte write strobes; bit i enables byte i
raddr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
rdata  out  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W]
clear_req  in  1  single-cycle pulse starting a full-array clear
busy  out  1  high while the clear sequencer runs

Behaviour:
- Reset: rst asserted -> all entries 0, FSM = IDLE, counter 0, busy 0; rdata therefore reads 0 for every address.
- Reads: rdata[k] = array[raddr[k]], purely combinational, zero cycles latency.
- Out-of-range read (raddr >= NUM_REGS) returns 0; out-of-range write is dropped.
- ZERO_REG=1: reads of address 0 return 0; writes to address 0 are dropped.
- Writes: at posedge clk with we=1 and busy=0, byte i of array[waddr] <= wdata byte i for each set wstrb[i]; unstrobed bytes are held. wstrb=0 -> no change.
- FSM states: IDLE, CLEAR.
- IDLE -> CLEAR on clear_req=1: counter <= 0, busy <= 1 from the next cycle.
- CLEAR: each cycle array[counter] <= 0 and counter++. When counter = NUM_REGS-1, that entry is zeroed, FSM -> IDLE and busy -> 0 on the same edge. Total busy = NUM_REGS cycles.
- Simultaneous clear_req and we in IDLE: the write commits on that edge, then the sweep zeroes it.
- In CLEAR, we is ignored (the write is dropped, not queued) and clear_req is ignored (no restart).
- Reads during CLEAR return current contents: entries below counter read 0, others read their old values.
- rst mid-clear: immediate return to the reset state; the sweep is abandoned.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-through forwarding. If we=1, busy=0 and raddr[k]=waddr (in range, not zero-reg-masked), rdata[k] = strobe-merged {wdata where wstrb set, stored byte otherwise} in the same cycle.
- Undefined: rdata[k] shows the pre-write value until after the edge, which matches the existing core behaviour.

Decomposition:
- Package regfile_pkg: FSM enum rf_state_t {IDLE, CLEAR}; function byte_merge(old, new, strb) shared by the write path and the bypass path; default-width constants.
- Sub-module regfile_clear_seq: FSM plus counter; outputs busy, clr_we, clr_addr. The top module holds the array, the read muxes and the bypass logic.

Test Plan:
- Reset then read all addresses on both ports -> 0x00000000 everywhere; busy=0.
- Write 0xDEADBEEF to r5 with wstrb=4'b1111, next cycle write 0x000000AA to r5 with wstrb=4'b0001 -> r5 reads 0xDEADBEAA.
- Write 0x12345678 to r0 (ZERO_REG=1) -> r0 reads 0; repeat with ZERO_REG=0 -> r0 reads 0x12345678.
- Fill r1..r31 with their index, pulse clear_req -> busy high for exactly 32 cycles; we pulses during that window have no effect; afterwards all entries read 0.
- Assert rst at sweep cycle 10 -> busy=0 immediately and all entries read 0; a following write of 0x55 to r3 succeeds.
- REGFILE_BYPASS_EN: with r7=0x11111111, write 0xFFFFFFFF to r7 with wstrb=4'b0011 while raddr0=7 -> same-cycle rdata0=0x1111FFFF; without the macro -> rdata0=0x11111111 until the edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, default widths and byte-merge helper for the register file
package regfile_pkg;

  typedef enum logic [0:0] {IDLE, CLEAR} rf_state_t;

  localparam int DEFAULT_DATA_W   = 32;
  localparam int DEFAULT_NUM_REGS = 32;
  localparam int DEFAULT_NUM_RD   = 2;

  // Widest register the merge helper handles; callers size-cast in and out.
  localparam int MERGE_W      = 512;
  localparam int MERGE_STRB_W = MERGE_W / 8;

  function automatic logic [MERGE_W-1:0] byte_merge(
    input logic [MERGE_W-1:0]      oldVal,
    input logic [MERGE_W-1:0]      newVal,
    input logic [MERGE_STRB_W-1:0] strb
  );
    logic [MERGE_W-1:0] merged;
    merged = oldVal;
    for (int i = 0; i < MERGE_STRB_W; i++) begin
      if (strb[i]) merged[i*8 +: 8] = newVal[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/regfile_multiport_if.sv
// rtl/regfile_multiport_if.sv - write, read and clear signals of the multiport register file
interface regfile_multiport_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int STRB_W = DATA_W / 8;

  logic                     we;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        wdata;
  logic [STRB_W-1:0]        wstrb;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic                     clear_req;
  logic                     busy;

  modport master (output we, waddr, wdata, wstrb, raddr, clear_req, input rdata, busy);
  modport slave  (input we, waddr, wdata, wstrb, raddr, clear_req, output rdata, busy);

endinterface

// File: rtl/regfile_clear_seq.sv
// rtl/regfile_clear_seq.sv - clear sequencer: zeroes one entry per cycle after clear_req
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = 32,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clearReq,
  output logic              busy,
  output logic              clrWe,
  output logic [ADDR_W-1:0] clrAddr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  rf_state_t         state, stateNext;
  logic [ADDR_W-1:0] cnt, cntNext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // A request while sweeping is ignored; the sweep always runs to completion.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE: begin
        if (clearReq) begin
          stateNext = CLEAR;
          cntNext   = '0;
        end
      end
      CLEAR: begin
        if (cnt == LAST_ADDR) begin
          stateNext = IDLE;
          cntNext   = '0;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  assign busy    = (state == CLEAR);
  assign clrWe   = busy;
  assign clrAddr = cnt;

endmodule

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - multiport register file with byte strobes, zero register and clear sweep
// Optional same-cycle write-through forwarding when REGFILE_BYPASS_EN is defined.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int NUM_RD   = DEFAULT_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input logic                clk,
  input logic                rst,
  regfile_multiport_if.slave bus
);

  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [NUM_REGS];
  logic              busy;
  logic              clrWe;
  logic [ADDR_W-1:0] clrAddr;
  logic              wrOk;
  logic [DATA_W-1:0] wrMerged;

  function automatic logic addrLive(input logic [ADDR_W-1:0] a);
    return (32'(a) < NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  function automatic logic [DATA_W-1:0] mergeWord(
    input logic [DATA_W-1:0] oldVal,
    input logic [DATA_W-1:0] newVal,
    input logic [STRB_W-1:0] strb
  );
    return DATA_W'(byte_merge(MERGE_W'(oldVal), MERGE_W'(newVal), MERGE_STRB_W'(strb)));
  endfunction

  regfile_clear_seq #(.NUM_REGS(NUM_REGS)) uClearSeq (
    .clk      (clk),
    .rst      (rst),
    .clearReq (bus.clear_req),
    .busy     (busy),
    .clrWe    (clrWe),
    .clrAddr  (clrAddr)
  );

  assign bus.busy = busy;

  // Out-of-range and zero-register writes are dropped here, so the array never sees them.
  assign wrOk     = bus.we && !busy && addrLive(bus.waddr);
  assign wrMerged = mergeWord(mem[bus.waddr], bus.wdata, bus.wstrb);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (clrWe) begin
      mem[clrAddr] <= '0;
    end else if (wrOk) begin
      mem[bus.waddr] <= wrMerged;
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    ra        = '0;
    bus.rdata = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = bus.raddr[k*ADDR_W +: ADDR_W];
      if (addrLive(ra)) begin
`ifdef REGFILE_BYPASS_EN
        if (wrOk && (ra == bus.waddr)) bus.rdata[k*DATA_W +: DATA_W] = wrMerged;
        else                           bus.rdata[k*DATA_W +: DATA_W] = mem[ra];
`else
        bus.rdata[k*DATA_W +: DATA_W] = mem[ra];
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - scoreboard bench for regfile_multiport (default and ZERO_REG=0/20-entry builds)
module tb_regfile_multiport;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_multiport_if #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2)) ifA ();
  regfile_multiport_if #(.DATA_W(32), .NUM_REGS(20), .NUM_RD(2)) ifB ();

  regfile_multiport #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .ZERO_REG(1)) dutA (
    .clk (clk), .rst (rst), .bus (ifA.slave));
  regfile_multiport #(.DATA_W(32), .NUM_REGS(20), .NUM_RD(2), .ZERO_REG(0)) dutB (
    .clk (clk), .rst (rst), .bus (ifB.slave));

  typedef struct {
    string       name;
    int          kind;   // 0: dutA rdata, 1: dutA busy, 2: dutB rdata
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   nChecks = 0;
  int   nFails  = 0;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.kind)
        0:       act = ifA.rdata[e.port*32 +: 32];
        1:       act = {31'b0, ifA.busy};
        default: act = ifB.rdata[e.port*32 +: 32];
      endcase
      nChecks++;
      if (act !== e.exp) begin
        nFails++;
        $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", e.name, act, e.exp, $time);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expA(input int port, input logic [4:0] addr, input logic [31:0] exp, input string nm);
    ifA.raddr[port*5 +: 5] = addr;
    q.push_back('{nm, 0, port, exp});
  endtask

  task automatic expB(input logic [4:0] addr, input logic [31:0] exp, input string nm);
    ifB.raddr[4:0] = addr;
    q.push_back('{nm, 2, 0, exp});
  endtask

  task automatic expBusy(input bit b, input string nm);
    q.push_back('{nm, 1, 0, {31'b0, b}});
  endtask

  task automatic wrA(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
    ifA.we = 1'b1; ifA.waddr = addr; ifA.wdata = data; ifA.wstrb = strb;
    cyc();
    ifA.we = 1'b0;
  endtask

  task automatic wrB(input logic [4:0] addr, input logic [31:0] data);
    ifB.we = 1'b1; ifB.waddr = addr; ifB.wdata = data; ifB.wstrb = 4'hF;
    cyc();
    ifB.we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ifA.we = 0; ifA.waddr = '0; ifA.wdata = '0; ifA.wstrb = '0; ifA.raddr = '0; ifA.clear_req = 0;
    ifB.we = 0; ifB.waddr = '0; ifB.wdata = '0; ifB.wstrb = '0; ifB.raddr = '0; ifB.clear_req = 0;
    repeat (3) @(posedge clk);
    #1;
    expBusy(1'b0, "busy_in_reset");
    rst = 1'b0;
    cyc();

    // Reset state: every entry reads zero on both ports.
    for (int i = 0; i < 32; i++) begin
      expA(0, 5'(i), 32'h0, "reset_rd_p0");
      expA(1, 5'(31 - i), 32'h0, "reset_rd_p1");
      if (i == 0) expBusy(1'b0, "reset_busy");
      cyc();
    end

    // Byte strobes.
    wrA(5'd5, 32'hDEADBEEF, 4'hF);
    wrA(5'd5, 32'h000000AA, 4'h1);
    expA(0, 5'd5, 32'hDEADBEAA, "strb_low_byte");
    cyc();
    wrA(5'd5, 32'h00000000, 4'h0);
    expA(1, 5'd5, 32'hDEADBEAA, "strb_zero");
    cyc();
    wrA(5'd5, 32'h99887766, 4'hA);
    expA(0, 5'd5, 32'h99AD77AA, "strb_mixed");
    cyc();

    // Zero register on A, ordinary r0 and out-of-range handling on B.
    wrA(5'd0, 32'h12345678, 4'hF);
    expA(0, 5'd0, 32'h0, "zero_reg_a");
    expB(5'd0, 32'h0, "b_reset_r0");
    cyc();
    wrB(5'd0, 32'h12345678);
    expB(5'd0, 32'h12345678, "b_r0_plain");
    cyc();
    wrB(5'd19, 32'hAABBCCDD);
    expB(5'd19, 32'hAABBCCDD, "b_last_entry");
    cyc();
    wrB(5'd25, 32'h00000099);
    expB(5'd25, 32'h0, "b_out_of_range");
    cyc();

    // Full clear sweep with a simultaneous write, blocked writes and an ignored re-request.
    for (int i = 1; i < 32; i++) wrA(5'(i), 32'(i), 4'hF);
    ifA.clear_req = 1'b1;
    ifA.we = 1'b1; ifA.waddr = 5'd2; ifA.wdata = 32'h77; ifA.wstrb = 4'hF;
    cyc();
    ifA.clear_req = 1'b0; ifA.we = 1'b0;
    for (int j = 0; j <= 32; j++) begin
      expBusy(j < 32, "busy_sweep");
      if (j == 1) begin
        expA(0, 5'd2, 32'h77, "sim_write_commit");
        expA(1, 5'd1, 32'h1, "pre_sweep_r1");
      end
      if (j == 10) begin
        expA(0, 5'd9, 32'h0, "swept_r9");
        expA(1, 5'd10, 32'hA, "unswept_r10");
      end
      ifA.clear_req = (j == 15);
      ifA.we        = (j == 20) || (j == 31);
      ifA.waddr     = (j == 20) ? 5'd3 : 5'd4;
      ifA.wdata     = 32'hFF;
      ifA.wstrb     = 4'hF;
      cyc();
    end
    ifA.we = 1'b0; ifA.clear_req = 1'b0;
    for (int i = 0; i < 32; i++) begin
      expA(0, 5'(i), 32'h0, "post_clear_p0");
      expA(1, 5'(31 - i), 32'h0, "post_clear_p1");
      cyc();
    end

    // Reset in the middle of a sweep.
    wrA(5'd3, 32'h3, 4'hF);
    wrA(5'd20, 32'h14, 4'hF);
    ifA.clear_req = 1'b1;
    cyc();
    ifA.clear_req = 1'b0;
    repeat (10) cyc();
    rst = 1'b1;
    expBusy(1'b0, "rst_mid_busy");
    expA(0, 5'd20, 32'h0, "rst_mid_r20");
    expA(1, 5'd3, 32'h0, "rst_mid_r3");
    cyc();
    rst = 1'b0;
    expBusy(1'b0, "rst_no_resume");
    cyc();
    wrA(5'd3, 32'h55, 4'hF);
    expA(0, 5'd3, 32'h55, "write_after_rst");
    expBusy(1'b0, "idle_after_rst");
    cyc();

    // Same-cycle forwarding (or its absence) on a partial-strobe write.
    wrA(5'd7, 32'h11111111, 4'hF);
    ifA.we = 1'b1; ifA.waddr = 5'd7; ifA.wdata = 32'hFFFFFFFF; ifA.wstrb = 4'b0011;
`ifdef REGFILE_BYPASS_EN
    expA(0, 5'd7, 32'h1111FFFF, "bypass_same_cycle");
`else
    expA(0, 5'd7, 32'h11111111, "no_bypass_same_cycle");
`endif
    cyc();
    ifA.we = 1'b0;
    expA(0, 5'd7, 32'h1111FFFF, "after_edge_r7");
    cyc();

    cyc();

    // Direct final-state checks.
    ifA.raddr[9:5] = 5'd3;
    ifB.raddr[4:0] = 5'd19;
    #1;
    nChecks++;
    if (ifA.rdata[31:0] !== 32'h1111FFFF) begin
      nFails++;
      $display("FAIL final_r7: got 0x%08h expected 0x1111FFFF at %0t", ifA.rdata[31:0], $time);
    end
    nChecks++;
    if (ifA.rdata[63:32] !== 32'h00000055) begin
      nFails++;
      $display("FAIL final_r3: got 0x%08h expected 0x00000055 at %0t", ifA.rdata[63:32], $time);
    end
    nChecks++;
    if (ifA.busy !== 1'b0) begin
      nFails++;
      $display("FAIL final_busy: got %b expected 0 at %0t", ifA.busy, $time);
    end
    nChecks++;
    if (ifB.rdata[31:0] !== 32'h00000000) begin
      nFails++;
      $display("FAIL final_b_r19: got 0x%08h expected 0x00000000 at %0t", ifB.rdata[31:0], $time);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
